// File: rtl/psram_arb_if.sv
// Requester-side bundle for the two-port PSRAM arbiter: port 0 (core) and port 1 (DMA).
// The arbiter uses the slave modport; a requester-side model uses master.
interface psram_arb_if;
  logic        p0_req;
  logic        p0_we;
  logic [22:0] p0_a;
  logic [7:0]  p0_din;
  logic [7:0]  p0_dout;
  logic        p0_ack;

  logic        p1_req;
  logic        p1_we;
  logic [22:0] p1_a;
  logic [7:0]  p1_din;
  logic [7:0]  p1_dout;
  logic        p1_ack;

  modport master (
    output p0_req, p0_we, p0_a, p0_din,
    input  p0_dout, p0_ack,
    output p1_req, p1_we, p1_a, p1_din,
    input  p1_dout, p1_ack
  );

  modport slave (
    input  p0_req, p0_we, p0_a, p0_din,
    output p0_dout, p0_ack,
    input  p1_req, p1_we, p1_a, p1_din,
    output p1_dout, p1_ack
  );
endinterface

// File: rtl/psram_arb.sv
// Two-port arbiter and strobe sequencer for an asynchronous 16-bit PSRAM.
// Port 0 has priority; port 1 is forced through after STARVE consecutive contested losses.
module psram_arb #(
  parameter int unsigned T_ACC  = 5,
  parameter int unsigned T_REC  = 1,
  parameter int unsigned STARVE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  psram_arb_if.slave  bus,
  output logic [21:0] ram_a,
  output logic [15:0] ram_dq_o,
  output logic        ram_dq_oe,
  input  logic [15:0] ram_dq_i,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        ram_lb_n,
  output logic        ram_ub_n,
  output logic        ram_zz_n
);

  localparam int unsigned CntMax = (T_ACC > T_REC) ? T_ACC : T_REC;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;
  localparam int unsigned StW    = $clog2(STARVE + 1);

  localparam logic [CntW-1:0] AccLast   = CntW'(T_ACC - 1);
  localparam logic [CntW-1:0] AccPenult = CntW'(T_ACC - 2);
  localparam logic [CntW-1:0] RecLast   = CntW'(T_REC - 1);
  localparam logic [StW-1:0]  StarveMax = StW'(STARVE);

  typedef enum logic [1:0] {StIdle, StAccess, StRecover} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic            port_q, port_d;
  logic            we_q, we_d;
  logic            a0_q, a0_d;
  logic [21:0]     ram_a_q, ram_a_d;
  logic [15:0]     dq_o_q, dq_o_d;
  logic            dq_oe_q, dq_oe_d;
  logic            ce_n_q, ce_n_d;
  logic            oe_n_q, oe_n_d;
  logic            we_n_q, we_n_d;
  logic            lb_n_q, lb_n_d;
  logic            ub_n_q, ub_n_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic [7:0]      dout0_q, dout0_d;
  logic [7:0]      dout1_q, dout1_d;

  logic            win1;
  logic            sel_we;
  logic [22:0]     sel_a;
  logic [7:0]      sel_din;
  logic [7:0]      rd_byte;

  assign win1    = bus.p1_req & (~bus.p0_req | (starve_q == StarveMax));
  assign sel_we  = win1 ? bus.p1_we  : bus.p0_we;
  assign sel_a   = win1 ? bus.p1_a   : bus.p0_a;
  assign sel_din = win1 ? bus.p1_din : bus.p0_din;
  assign rd_byte = a0_q ? ram_dq_i[15:8] : ram_dq_i[7:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    port_d   = port_q;
    we_d     = we_q;
    a0_d     = a0_q;
    ram_a_d  = ram_a_q;
    dq_o_d   = dq_o_q;
    dq_oe_d  = dq_oe_q;
    ce_n_d   = ce_n_q;
    oe_n_d   = oe_n_q;
    we_n_d   = we_n_q;
    lb_n_d   = lb_n_q;
    ub_n_d   = ub_n_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    dout0_d  = dout0_q;
    dout1_d  = dout1_q;

    unique case (state_q)
      StIdle: begin
        if (bus.p0_req || bus.p1_req) begin
          // Strobes are registered on the grant edge so ACCESS starts asserted.
          state_d = StAccess;
          cnt_d   = '0;
          port_d  = win1;
          we_d    = sel_we;
          a0_d    = sel_a[0];
          ram_a_d = sel_a[22:1];
          dq_o_d  = {sel_din, sel_din};
          dq_oe_d = sel_we;
          ce_n_d  = 1'b0;
          oe_n_d  = sel_we;
          we_n_d  = ~sel_we;
          lb_n_d  = sel_a[0];
          ub_n_d  = ~sel_a[0];
          if (win1) begin
            starve_d = '0;
          end else if (bus.p1_req && starve_q != StarveMax) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      StAccess: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AccLast) begin
          state_d = StRecover;
          cnt_d   = '0;
          dq_oe_d = 1'b0;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          lb_n_d  = 1'b1;
          ub_n_d  = 1'b1;
          ack0_d  = ~port_q;
          ack1_d  = port_q;
          if (!we_q) begin
            if (port_q) dout1_d = rd_byte;
            else        dout0_d = rd_byte;
          end
        end else if (cnt_q == AccPenult) begin
          // Release WE one cycle early so data is held with CE still low.
          we_n_d = 1'b1;
        end
      end
      StRecover: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RecLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      starve_q <= '0;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      a0_q     <= 1'b0;
      ram_a_q  <= '0;
      dq_o_q   <= '0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      dout0_q  <= '0;
      dout1_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      port_q   <= port_d;
      we_q     <= we_d;
      a0_q     <= a0_d;
      ram_a_q  <= ram_a_d;
      dq_o_q   <= dq_o_d;
      dq_oe_q  <= dq_oe_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      lb_n_q   <= lb_n_d;
      ub_n_q   <= ub_n_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      dout0_q  <= dout0_d;
      dout1_q  <= dout1_d;
    end
  end

  assign ram_a       = ram_a_q;
  assign ram_dq_o    = dq_o_q;
  assign ram_dq_oe   = dq_oe_q;
  assign ram_ce_n    = ce_n_q;
  assign ram_oe_n    = oe_n_q;
  assign ram_we_n    = we_n_q;
  assign ram_lb_n    = lb_n_q;
  assign ram_ub_n    = ub_n_q;
  assign ram_zz_n    = 1'b1;
  assign bus.p0_ack  = ack0_q;
  assign bus.p1_ack  = ack1_q;
  assign bus.p0_dout = dout0_q;
  assign bus.p1_dout = dout1_q;

endmodule

// File: tb/tb_psram_arb.sv
// Directed bench for psram_arb: single reads/writes, starvation rotation, held request,
// and asynchronous reset in the middle of an access.
module tb_psram_arb;

  logic        clk;
  logic        rst_n;
  logic [21:0] ram_a;
  logic [15:0] ram_dq_o;
  logic        ram_dq_oe;
  logic [15:0] ram_dq_i;
  logic        ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n, ram_zz_n;

  int checks = 0;
  int errors = 0;

  psram_arb_if bus ();

  psram_arb #(.T_ACC(5), .T_REC(1), .STARVE(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_a     (ram_a),
    .ram_dq_o  (ram_dq_o),
    .ram_dq_oe (ram_dq_oe),
    .ram_dq_i  (ram_dq_i),
    .ram_ce_n  (ram_ce_n),
    .ram_oe_n  (ram_oe_n),
    .ram_we_n  (ram_we_n),
    .ram_lb_n  (ram_lb_n),
    .ram_ub_n  (ram_ub_n),
    .ram_zz_n  (ram_zz_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation results gathered by observe(); cycle c = c-th rising edge after the call.
  int          c_ce, c_oe, c_we, c_dqoe, overlap;
  int          ack0_cyc[$];
  int          ack1_cyc[$];
  int          all_ack[$];
  int          seq[$];
  int          ce_start[$];
  bit          cap_valid;
  logic [21:0] cap_a;
  logic [15:0] cap_dq;
  logic        cap_lb, cap_ub;

  task automatic observe(input int n, input bit drop);
    logic prev_ce;
    c_ce = 0; c_oe = 0; c_we = 0; c_dqoe = 0; overlap = 0; cap_valid = 0;
    ack0_cyc.delete(); ack1_cyc.delete(); all_ack.delete(); seq.delete(); ce_start.delete();
    prev_ce = ram_ce_n;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (!ram_ce_n) c_ce++;
      if (!ram_oe_n) c_oe++;
      if (!ram_we_n) c_we++;
      if (ram_dq_oe) c_dqoe++;
      if (prev_ce && !ram_ce_n) ce_start.push_back(c);
      prev_ce = ram_ce_n;
      if (!ram_ce_n && !cap_valid) begin
        cap_valid = 1; cap_a = ram_a; cap_dq = ram_dq_o; cap_lb = ram_lb_n; cap_ub = ram_ub_n;
      end
      if (bus.p0_ack && bus.p1_ack) overlap++;
      if (bus.p0_ack) begin
        ack0_cyc.push_back(c); all_ack.push_back(c); seq.push_back(0);
        if (drop) bus.p0_req = 1'b0;
      end
      if (bus.p1_ack) begin
        ack1_cyc.push_back(c); all_ack.push_back(c); seq.push_back(1);
        if (drop) bus.p1_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ram_ce_n !== 1'b1) begin errors++; $display("FAIL rst_ce_n: got %b want 1", ram_ce_n); end
    checks++; if (ram_oe_n !== 1'b1) begin errors++; $display("FAIL rst_oe_n: got %b want 1", ram_oe_n); end
    checks++; if (ram_we_n !== 1'b1) begin errors++; $display("FAIL rst_we_n: got %b want 1", ram_we_n); end
    checks++; if ({ram_lb_n, ram_ub_n} !== 2'b11) begin errors++; $display("FAIL rst_lb_ub: got %b want 11", {ram_lb_n, ram_ub_n}); end
    checks++; if (ram_zz_n !== 1'b1) begin errors++; $display("FAIL rst_zz_n: got %b want 1", ram_zz_n); end
    checks++; if (ram_dq_oe !== 1'b0) begin errors++; $display("FAIL rst_dq_oe: got %b want 0", ram_dq_oe); end
    checks++; if (ram_a !== 22'h0) begin errors++; $display("FAIL rst_ram_a: got %h want 0", ram_a); end
    checks++; if (ram_dq_o !== 16'h0) begin errors++; $display("FAIL rst_dq_o: got %h want 0", ram_dq_o); end
    checks++; if ({bus.p0_ack, bus.p1_ack} !== 2'b00) begin errors++; $display("FAIL rst_acks: got %b want 00", {bus.p0_ack, bus.p1_ack}); end
    checks++; if ({bus.p0_dout, bus.p1_dout} !== 16'h0) begin errors++; $display("FAIL rst_douts: got %h want 0", {bus.p0_dout, bus.p1_dout}); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_p0_read;
    ram_dq_i = 16'hA55A;
    bus.p0_a = 23'h000101; bus.p0_we = 1'b0; bus.p0_din = 8'h00; bus.p0_req = 1'b1;
    observe(9, 1'b1);
    checks++; if (cap_a !== 22'h000080) begin errors++; $display("FAIL p0rd_ram_a: got %h want 000080", cap_a); end
    checks++; if ({cap_lb, cap_ub} !== 2'b10) begin errors++; $display("FAIL p0rd_lb_ub: got %b want 10", {cap_lb, cap_ub}); end
    checks++; if (c_oe != 5) begin errors++; $display("FAIL p0rd_oe_cycles: got %0d want 5", c_oe); end
    checks++; if (c_ce != 5) begin errors++; $display("FAIL p0rd_ce_cycles: got %0d want 5", c_ce); end
    checks++; if (c_we != 0 || c_dqoe != 0) begin errors++; $display("FAIL p0rd_no_write: got we %0d oe %0d want 0 0", c_we, c_dqoe); end
    checks++; if (ack0_cyc.size() != 1 || ack0_cyc[0] != 6) begin errors++; $display("FAIL p0rd_ack: got %0d acks first %0d want 1 at 6", ack0_cyc.size(), ack0_cyc.size() > 0 ? ack0_cyc[0] : -1); end
    checks++; if (bus.p0_dout !== 8'hA5) begin errors++; $display("FAIL p0rd_dout: got %h want a5", bus.p0_dout); end
    checks++; if (bus.p1_dout !== 8'h00) begin errors++; $display("FAIL p0rd_p1_dout: got %h want 00", bus.p1_dout); end
  endtask

  task automatic test_p1_write;
    bus.p1_a = 23'h420000; bus.p1_we = 1'b1; bus.p1_din = 8'h3C; bus.p1_req = 1'b1;
    observe(9, 1'b1);
    checks++; if (cap_a !== 22'h210000) begin errors++; $display("FAIL p1wr_ram_a: got %h want 210000", cap_a); end
    checks++; if ({cap_lb, cap_ub} !== 2'b01) begin errors++; $display("FAIL p1wr_lb_ub: got %b want 01", {cap_lb, cap_ub}); end
    checks++; if (cap_dq !== 16'h3C3C) begin errors++; $display("FAIL p1wr_dq_o: got %h want 3c3c", cap_dq); end
    checks++; if (c_dqoe != 5) begin errors++; $display("FAIL p1wr_dq_oe_cycles: got %0d want 5", c_dqoe); end
    checks++; if (c_we != 4) begin errors++; $display("FAIL p1wr_we_cycles: got %0d want 4", c_we); end
    checks++; if (c_oe != 0) begin errors++; $display("FAIL p1wr_oe_cycles: got %0d want 0", c_oe); end
    checks++; if (ack1_cyc.size() != 1 || ack1_cyc[0] != 6) begin errors++; $display("FAIL p1wr_ack: got %0d acks first %0d want 1 at 6", ack1_cyc.size(), ack1_cyc.size() > 0 ? ack1_cyc[0] : -1); end
    checks++; if (ack0_cyc.size() != 0) begin errors++; $display("FAIL p1wr_p0_ack: got %0d want 0", ack0_cyc.size()); end
    checks++; if (bus.p1_dout !== 8'h00 || bus.p0_dout !== 8'hA5) begin errors++; $display("FAIL p1wr_douts: got %h %h want 00 a5", bus.p1_dout, bus.p0_dout); end
  endtask

  task automatic test_starve;
    int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int bad_gap;
    ram_dq_i = 16'hA55A;
    bus.p0_a = 23'h000010; bus.p0_we = 1'b0;
    bus.p1_a = 23'h000021; bus.p1_we = 1'b0;
    bus.p0_req = 1'b1; bus.p1_req = 1'b1;
    observe(70, 1'b0);
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    checks++; if (seq.size() != 10) begin errors++; $display("FAIL starve_ack_count: got %0d want 10", seq.size()); end
    for (int i = 0; i < 10; i++) begin
      if (i < seq.size()) begin
        checks++;
        if (seq[i] != exp_seq[i]) begin errors++; $display("FAIL starve_grant_%0d: got port %0d want %0d", i, seq[i], exp_seq[i]); end
      end
    end
    bad_gap = 0;
    for (int i = 1; i < all_ack.size(); i++) if (all_ack[i] - all_ack[i-1] != 7) bad_gap++;
    checks++; if (bad_gap != 0 || all_ack.size() == 0 || all_ack[0] != 6) begin errors++; $display("FAIL starve_period: got %0d bad gaps want 0", bad_gap); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL starve_overlap: got %0d want 0", overlap); end
    checks++; if (bus.p0_dout !== 8'h5A || bus.p1_dout !== 8'hA5) begin errors++; $display("FAIL starve_douts: got %h %h want 5a a5", bus.p0_dout, bus.p1_dout); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    bus.p0_a = 23'h000101; bus.p0_we = 1'b0; bus.p0_req = 1'b1;
    ram_dq_i = 16'h5AC3;
    observe(14, 1'b0);
    bus.p0_req = 1'b0;
    checks++; if (ack0_cyc.size() != 2) begin errors++; $display("FAIL b2b_ack_count: got %0d want 2", ack0_cyc.size()); end
    if (ack0_cyc.size() == 2) begin
      checks++; if (ack0_cyc[1] - ack0_cyc[0] != 7) begin errors++; $display("FAIL b2b_spacing: got %0d want 7", ack0_cyc[1] - ack0_cyc[0]); end
    end
    checks++; if (ce_start.size() != 2 || ack0_cyc.size() == 0 || ce_start[1] != ack0_cyc[0] + 2) begin errors++; $display("FAIL b2b_restart: got %0d starts want 2nd at ack+2", ce_start.size()); end
    checks++; if (bus.p0_dout !== 8'h5A) begin errors++; $display("FAIL b2b_dout: got %h want 5a", bus.p0_dout); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    bit ack_seen;
    bus.p0_a = 23'h000002; bus.p0_we = 1'b1; bus.p0_din = 8'h77; bus.p0_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ram_we_n !== 1'b0 || ram_dq_oe !== 1'b1) begin errors++; $display("FAIL rmid_pre: got we_n %b dq_oe %b want 0 1", ram_we_n, ram_dq_oe); end
    rst_n = 1'b0;
    #1;
    checks++; if ({ram_ce_n, ram_oe_n, ram_we_n} !== 3'b111) begin errors++; $display("FAIL rmid_strobes: got %b want 111", {ram_ce_n, ram_oe_n, ram_we_n}); end
    checks++; if (ram_dq_oe !== 1'b0) begin errors++; $display("FAIL rmid_dq_oe: got %b want 0", ram_dq_oe); end
    checks++; if (bus.p0_dout !== 8'h00) begin errors++; $display("FAIL rmid_dout: got %h want 00", bus.p0_dout); end
    ack_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.p0_ack || bus.p1_ack) ack_seen = 1;
    end
    checks++; if (ack_seen) begin errors++; $display("FAIL rmid_no_ack: got ack want none"); end
    rst_n = 1'b1;
    observe(10, 1'b1);
    checks++; if (ack0_cyc.size() != 1 || ack0_cyc[0] != 6) begin errors++; $display("FAIL rmid_served: got %0d acks first %0d want 1 at 6", ack0_cyc.size(), ack0_cyc.size() > 0 ? ack0_cyc[0] : -1); end
    checks++; if (c_we != 4 || cap_dq !== 16'h7777 || cap_a !== 22'h000001) begin errors++; $display("FAIL rmid_write: got we %0d dq %h a %h want 4 7777 000001", c_we, cap_dq, cap_a); end
    checks++; if (bus.p0_dout !== 8'h00) begin errors++; $display("FAIL rmid_dout_after: got %h want 00", bus.p0_dout); end
  endtask

  initial begin
    rst_n = 1'b0;
    ram_dq_i = 16'h0;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_a = '0; bus.p0_din = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_a = '0; bus.p1_din = '0;
    test_reset();
    test_p0_read();
    test_p1_write();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psram_arb.md
Name: psram_arb

Overview:
- Two-port arbiter and timing sequencer for the single asynchronous 16-bit PSRAM.
- Shares the PSRAM between port 0 (VerilogBoy core ROM/RAM path, high priority) and port 1 (DMA requester, e.g. SD cartridge loader or framebuffer fetch).
- Generates registered CE/OE/WE/byte-lane strobes with parameterised access and recovery times.
- Sits between the memory-controller address mapping and the top-level RAM_* pins.

Parameters:
T_ACC, 5, PSRAM access cycles with CE low (minimum 2)
T_REC, 1, recovery cycles with CE high between accesses (minimum 1)
STARVE, 4, consecutive port-1 losses before port 1 is forced to win

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
p0_req  input  1  port 0 request, held high until p0_ack
p0_we  input  1  port 0 write (1) / read (0)
p0_a  input  23  port 0 byte address
p0_din  input  8  port 0 write data
p0_dout  output  8  port 0 read data, valid with p0_ack and held until the next p0 read ack
p0_ack  output  1  port 0 one-cycle completion pulse
p1_req, p1_we, p1_a, p1_din, p1_dout, p1_ack  same widths and semantics for port 1
ram_a  output  22  PSRAM word address
ram_dq_o  output  16  PSRAM write data
ram_dq_oe  output  1  DQ output enable, drives tristate at top
ram_dq_i  input  16  PSRAM read data
ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n  output  1 each  PSRAM strobes
ram_zz_n  output  1  sleep control, constant 1

Behaviour:
- Clocking and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; all ram_*_n = 1 except ram_zz_n = 1 (constant); ram_dq_oe = 0; ram_a = 0; ram_dq_o = 0; acks = 0; douts = 0x00; starve counter = 0.
- FSM states:
  - IDLE: evaluate requests.
  - ACCESS: T_ACC cycles.
  - RECOVER: T_REC cycles.
- Arbitration (IDLE only):
  - If both ports request, port 0 wins unless starve counter == STARVE; then port 1 wins.
  - Single requester wins.
  - Starve counter increments when port 1 loses a contested arbitration and clears when port 1 is granted. It saturates at STARVE.
- Grant edge (IDLE -> ACCESS) registers the winner's a, we, din and port id. Requester inputs are not sampled again until the next IDLE.
- Address mapping: ram_a = a[22:1]. a[0] = 0 selects the lower byte (lb_n = 0, ub_n = 1); a[0] = 1 selects the upper byte (ub_n = 0, lb_n = 1).
- Write data: din replicated to both bytes of ram_dq_o.
- ACCESS, read: ce_n = 0 and oe_n = 0 for all T_ACC cycles. ram_dq_i is sampled on the final ACCESS edge; the selected byte goes to the winner's dout.
- ACCESS, write: ce_n = 0; dq_oe = 1 for all T_ACC cycles; we_n = 0 for the first T_ACC-1 cycles and 1 in the last (data hold); oe_n = 1.
- ACCESS -> RECOVER: all strobes return to 1, dq_oe = 0, winner's ack = 1 for exactly the first RECOVER cycle.
- RECOVER -> IDLE after T_REC cycles.
- Latency:
  - Request seen at IDLE edge k: ACCESS occupies cycles k+1..k+T_ACC; ack is high in cycle k+T_ACC+1.
  - Back-to-back period per access = 1 + T_ACC + T_REC cycles.
- Requester rules:
  - A req still high during its ack cycle is not a new request; the arbiter is in RECOVER.
  - To issue a new request, req must remain or be high in IDLE with new a/we/din.
  - A req dropped mid-access is a protocol violation. The access completes and ack still pulses.
- Reset mid-access: strobes return to inactive immediately (asynchronous), no ack is issued, and dout is cleared.
- Non-winner dout is unchanged; a write ack leaves dout unchanged.

Test Plan:
- P0 read a = 0x000101, ram_dq_i = 0xA55A, T_ACC = 5 -> ram_a = 0x000080, ub_n = 0, oe_n low 5 cycles, p0_ack at k+6, p0_dout = 0xA5.
- P1 write a = 0x420000, din = 0x3C -> ram_a = 0x210000, lb_n = 0, dq_oe = 1 for 5 cycles, we_n low 4 cycles, ram_dq_o = 0x3C3C, p1_ack after 6 cycles, no p0 activity.
- Both req continuously -> grants P0 ×4, P1, P0 ×4, P1 …; period 7 cycles each, acks never overlap.
- P0 req held high through ack with the same address -> second access starts exactly T_REC + 1 cycles after ack; total 2 acks at 7-cycle spacing.
- rst_n low in ACCESS cycle 3 -> ce_n, oe_n, we_n = 1 and dq_oe = 0 combinationally; no ack; after release, FSM is in IDLE and a pending req is served normally.
